fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of reg_file.
- Owns the R15 update path: it reads PC_out from reg_file and drives PC_next back into it every cycle.
- Issues word fetches to instruction memory over a req/ready + rvalid handshake.
- Buffers one fetched instruction for decode with a valid/ack handshake.
- Handles branch redirects, stalls, and discard of in-flight stale fetches.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value driven on PC_next while in BOOT
PC_STEP, 4, byte increment applied to PC after each accepted fetch
NOP_INSTR, 32'hE1A0_0000, value held on instr out of reset and after flush (MOV r0,r0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
PC_out  in  32  current R15 from reg_file
PC_next  out  32  next R15 value; reg_file loads it every cycle
branch_taken  in  1  redirect request from execute, single-cycle pulse
branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0
stall  in  1  hazard stall from decode/execute
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, equal to {PC_out[31:2],2'b00}
imem_ready  in  1  memory accepts the request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  fetched instruction word
instr  out  32  buffered instruction to decode
instr_valid  out  1  instr holds a valid, unconsumed instruction
instr_ack  in  1  decode consumes instr this cycle

Behaviour:
- Single clock clk; reset is asynchronous, active-low on rst_n.
- Reset values: state=BOOT, imem_req=0, instr=NOP_INSTR, instr_valid=0, discard=0.
  - PC_next=RESET_VECTOR while in BOOT (combinational from state).
- States (enum fetch_state_t): BOOT, REQ, WAIT, HOLD.
- BOOT: lasts exactly 1 cycle after rst_n deasserts. PC_next=RESET_VECTOR. Next state is REQ. branch_taken is ignored in BOOT.
- REQ:
  - imem_req = !stall && !branch_taken.
  - imem_req && imem_ready: PC_next=PC_out+PC_STEP (mod 2^32, wraps FFFF_FFFC->0000_0000); go to WAIT.
  - Otherwise PC_next=PC_out and the state stays REQ.
- WAIT:
  - imem_req=0.
  - imem_rvalid && !discard: instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - imem_rvalid && discard: drop the data, clear discard, go to REQ. instr and instr_valid are unchanged.
  - PC_next=PC_out unless a branch occurs.
- HOLD:
  - instr_valid=1.
  - instr_ack && !stall: instr_valid<=0, go to REQ; the next fetch is issued in the following cycle.
  - stall=1 means any ack is ignored and the state stays HOLD.
- Branch (any state except BOOT) has highest priority and overrides stall and ack:
  - PC_next=branch_target&~3 in that cycle.
  - REQ: imem_req is forced to 0 that cycle; stay in REQ.
  - WAIT: set discard=1 and stay in WAIT. If imem_rvalid arrives in the same cycle, that data is dropped and the state goes to REQ with discard=0.
  - HOLD: instr<=NOP_INSTR, instr_valid<=0, go to REQ.
- At most one outstanding request. Memory latency from imem_ready to imem_rvalid is unbounded (≥1 cycle).
- Reset mid-fetch: all state clears asynchronously. A later rvalid for the lost request arrives in BOOT/REQ and is ignored.
- Throughput: at best 1 instruction per 3 cycles (REQ, WAIT, HOLD).

Decomposition:
- Package arm_pkg holds: fetch_state_t enum, NOP_INSTR and PC_STEP constants, and a 32-bit word_t typedef shared with reg_file.
- One natural sub-module, pc_next_mux: combinational priority select of RESET_VECTOR / branch_target / PC_out+PC_STEP / PC_out from state and event flags.
- The FSM and buffer remain in fetch_unit.

Test Plan:
1. Reset then release, memory ready=1, rvalid 1 cycle later with rdata=E3A01005:
   - PC_next=0 during BOOT.
   - imem_addr=0 in REQ; PC_next=4.
   - instr=E3A01005 with instr_valid=1 the cycle after rvalid.
2. Steady fetch with ack every HOLD cycle:
   - PC_out sequence 0,4,8,C with imem_addr matching.
   - One accepted request every 3 cycles.
3. branch_taken=1 with target=0000_0103 while in WAIT, then rvalid with rdata=DEADBEEF:
   - PC_next=0000_0100 that cycle.
   - DEADBEEF is never presented; instr_valid stays 0.
   - Next imem_addr=0000_0100.
4. stall=1 held 5 cycles in HOLD with instr_ack=1:
   - instr_valid stays 1, instr is stable, PC_next=PC_out, no imem_req.
   - After stall drops, ack is consumed and REQ follows.
5. PC_out=FFFF_FFFC with fetch accepted:
   - PC_next=0000_0000 (wrap).
6. rst_n asserted in WAIT with instr_valid=1 from a prior fetch, then rvalid arrives during reset and in BOOT:
   - Outputs immediately go to instr=E1A00000, instr_valid=0, imem_req=0.
   - The late rvalid is ignored.

Source files
------------

// File: rtl/arm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arm_pkg : types and constants shared by the fetch stage and reg_file. rev 1.0
// ---------------------------------------------------------------------------
package arm_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam word_t NOP_INSTR = 32'hE1A0_0000;
  localparam word_t PC_STEP   = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit_if : imem request/response and decode hand-off bundle. rev 1.0
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  import arm_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ready;
  logic  imem_rvalid;
  word_t imem_rdata;
  word_t instr;
  logic  instr_valid;
  logic  instr_ack;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ack
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ready, imem_rvalid, imem_rdata, instr_ack
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_pc_next_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_next_mux : priority select of the next R15 value. rev 1.0
// ---------------------------------------------------------------------------
module pc_next_mux #(
  parameter arm_pkg::word_t RESET_VECTOR = 32'h0000_0000,
  parameter arm_pkg::word_t PC_STEP      = arm_pkg::PC_STEP
) (
  input  logic           in_boot,
  input  logic           branch,
  input  logic           accept,
  input  arm_pkg::word_t branch_target,
  input  arm_pkg::word_t pc_cur,
  output arm_pkg::word_t pc_next
);
  import arm_pkg::*;

  always_comb begin
    pc_next = pc_cur;
    if (in_boot)
      pc_next = RESET_VECTOR;
    else if (branch)
      pc_next = {branch_target[31:2], 2'b00};
    else if (accept)
      pc_next = pc_cur + PC_STEP;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : instruction fetch FSM with one-entry decode buffer. rev 1.0
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter arm_pkg::word_t RESET_VECTOR = 32'h0000_0000,
  parameter arm_pkg::word_t PC_STEP      = arm_pkg::PC_STEP,
  parameter arm_pkg::word_t NOP_INSTR    = arm_pkg::NOP_INSTR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  arm_pkg::word_t PC_out,
  output arm_pkg::word_t PC_next,
  input  logic           branch_taken,
  input  arm_pkg::word_t branch_target,
  input  logic           stall,
  fetch_unit_if.master   bus
);
  import arm_pkg::*;

  fetch_state_t state;
  logic         discard;
  word_t        instr_q;
  logic         instr_valid_q;

  logic in_boot;
  logic branch;
  logic req;
  logic accept;

  // Branches are meaningless until the reset vector has been loaded.
  assign in_boot = (state == BOOT);
  assign branch  = branch_taken && !in_boot;
  assign req     = (state == REQ) && !stall && !branch_taken;
  assign accept  = req && bus.imem_ready;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = {PC_out[31:2], 2'b00};
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;

  pc_next_mux #(
    .RESET_VECTOR (RESET_VECTOR),
    .PC_STEP      (PC_STEP)
  ) u_pc_next_mux (
    .in_boot       (in_boot),
    .branch        (branch),
    .accept        (accept),
    .branch_target (branch_target),
    .pc_cur        (PC_out),
    .pc_next       (PC_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      discard       <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (accept)
            state <= WAIT;
        end
        WAIT: begin
          // A response racing a branch belongs to the old path and is dropped.
          if (bus.imem_rvalid) begin
            if (discard || branch) begin
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              instr_q       <= bus.imem_rdata;
              instr_valid_q <= 1'b1;
              state         <= HOLD;
            end
          end else if (branch) begin
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (branch) begin
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            state         <= REQ;
          end else if (bus.instr_ack && !stall) begin
            instr_valid_q <= 1'b0;
            state         <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire
